// File: rtl/cg_index_decoder.sv
// Index-to-one-hot decoder with a one-deep valid/ready output register,
// plus a sticky mask of every decoded bit and its population count.
module cg_index_decoder #(
  parameter int BITS_WIDTH  = 16,
  parameter int INDEX_WIDTH = $clog2(BITS_WIDTH)
) (
  input  logic                            i_clk,
  input  logic                            i_rst,
  input  logic [INDEX_WIDTH-1:0]          i_index,
  input  logic                            i_en,
  output logic                            o_ready,
  output logic [BITS_WIDTH-1:0]           o_bits,
  output logic                            o_valid,
  input  logic                            i_ready,
  output logic                            o_err,
  input  logic                            i_clear,
  output logic [BITS_WIDTH-1:0]           o_mask,
  output logic [$clog2(BITS_WIDTH+1)-1:0] o_count
);
  localparam int CW = $clog2(BITS_WIDTH + 1);

  logic                  r_valid;
  logic [BITS_WIDTH-1:0] r_bits;
  logic                  r_err;
  logic [BITS_WIDTH-1:0] r_mask;
  logic [CW-1:0]         r_count;

  logic                  w_accept;
  logic                  w_deliver;
  logic                  w_oor;
  logic [BITS_WIDTH-1:0] w_dec;
  logic [BITS_WIDTH-1:0] w_mask_nxt;
  logic [CW-1:0]         w_count_nxt;

  // The output register frees up in the same cycle it is drained.
  assign o_ready   = !r_valid || i_ready;
  assign w_accept  = i_en && o_ready;
  assign w_deliver = r_valid && i_ready;

  // Out-of-range indices match no comparator, so the decode is already zero.
  assign w_oor = 32'(i_index) >= BITS_WIDTH;

  for (genvar b = 0; b < BITS_WIDTH; b++) begin : g_dec
    assign w_dec[b] = (32'(i_index) == b);
  end

  // Clear is applied before the OR of a same-cycle accept.
  always_comb begin
    w_mask_nxt = i_clear ? '0 : r_mask;
    if (w_accept) w_mask_nxt = w_mask_nxt | w_dec;
  end

  always_comb begin
    w_count_nxt = '0;
    for (int i = 0; i < BITS_WIDTH; i++)
      w_count_nxt = w_count_nxt + CW'(w_mask_nxt[i]);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_valid <= 1'b0;
      r_bits  <= '0;
      r_err   <= 1'b0;
    end else if (w_accept) begin
      r_valid <= 1'b1;
      r_bits  <= w_dec;
      r_err   <= w_oor;
    end else if (w_deliver) begin
      r_valid <= 1'b0;
    end
  end

  // Count is registered from the same next-mask so it never lags o_mask.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_mask  <= '0;
      r_count <= '0;
    end else begin
      r_mask  <= w_mask_nxt;
      r_count <= w_count_nxt;
    end
  end

  assign o_valid = r_valid;
  assign o_bits  = r_bits;
  assign o_err   = r_err;
  assign o_mask  = r_mask;
  assign o_count = r_count;
endmodule

// File: tb/tb_cg_index_decoder.sv
// Bench for cg_index_decoder: a 16-bit and a 12-bit instance share one stimulus
// stream; directed table, out-of-range sequence and random traffic vs a model.
module tb_cg_index_decoder;
  logic clk;
  logic rst, en, rdy, clr;
  logic [3:0] idx;

  logic        a_ready, a_valid, a_err;
  logic [15:0] a_bits, a_mask;
  logic [4:0]  a_count;
  logic        b_ready, b_valid, b_err;
  logic [11:0] b_bits, b_mask;
  logic [3:0]  b_count;

  int total = 0;
  int bad   = 0;

  cg_index_decoder #(.BITS_WIDTH(16), .INDEX_WIDTH(4)) dut_a (
    .i_clk(clk), .i_rst(rst), .i_index(idx), .i_en(en), .o_ready(a_ready),
    .o_bits(a_bits), .o_valid(a_valid), .i_ready(rdy), .o_err(a_err),
    .i_clear(clr), .o_mask(a_mask), .o_count(a_count));

  cg_index_decoder #(.BITS_WIDTH(12), .INDEX_WIDTH(4)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_index(idx), .i_en(en), .o_ready(b_ready),
    .o_bits(b_bits), .o_valid(b_valid), .i_ready(rdy), .o_err(b_err),
    .i_clear(clr), .o_mask(b_mask), .o_count(b_count));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: one entry per instance, described as values, not logic.
  int          bw[2] = '{16, 12};
  logic        m_valid[2];
  logic [15:0] m_bits[2];
  logic        m_err[2];
  logic [15:0] m_mask[2];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_edge(input logic e, input logic [3:0] ix, input logic r,
                            input logic c, input logic rs);
    for (int k = 0; k < 2; k++) begin
      if (rs) begin
        m_valid[k] = 0; m_bits[k] = 0; m_err[k] = 0; m_mask[k] = 0;
      end else begin
        logic        acc, del;
        logic [15:0] nm, d;
        acc = e && (!m_valid[k] || r);
        del = m_valid[k] && r;
        nm  = c ? 16'h0 : m_mask[k];
        if (acc) begin
          d = (int'(ix) < bw[k]) ? (16'h1 << ix) : 16'h0;
          m_bits[k]  = d;
          m_err[k]   = (int'(ix) >= bw[k]);
          m_valid[k] = 1;
          nm = nm | d;
        end else if (del) begin
          m_valid[k] = 0;
        end
        m_mask[k] = nm;
      end
    end
  endtask

  task automatic check_model();
    chk("a_valid", a_valid, m_valid[0]);
    chk("a_err",   a_err,   m_err[0]);
    chk("a_mask",  a_mask,  m_mask[0]);
    chk("a_count", a_count, $countones(m_mask[0]));
    if (m_valid[0]) chk("a_bits", a_bits, m_bits[0]);
    chk("b_valid", b_valid, m_valid[1]);
    chk("b_err",   b_err,   m_err[1]);
    chk("b_mask",  {4'h0, b_mask}, m_mask[1]);
    chk("b_count", b_count, $countones(m_mask[1]));
    if (m_valid[1]) chk("b_bits", {4'h0, b_bits}, m_bits[1]);
  endtask

  // One clock: drive, check combinational ready, edge, check registered state.
  task automatic cyc(input logic e, input logic [3:0] ix, input logic r,
                     input logic c, input logic rs);
    en = e; idx = ix; rdy = r; clr = c; rst = rs;
    #1;
    if (!rs) begin
      chk("a_ready_pre", a_ready, !m_valid[0] || r);
      chk("b_ready_pre", b_ready, !m_valid[1] || r);
    end
    @(posedge clk);
    model_edge(e, ix, r, c, rs);
    #1;
    check_model();
  endtask

  typedef struct {
    logic        en;
    logic [3:0]  idx;
    logic        rdy, clr, rst;
    logic        ev;
    logic [15:0] eb;
    logic [15:0] em;
    int          ec;
    logic        erdy;
  } vec_t;

  function automatic vec_t v(logic e, logic [3:0] ix, logic r, logic c, logic rs,
                             logic ev, logic [15:0] eb, logic [15:0] em, int ec,
                             logic erdy);
    vec_t t;
    t.en = e; t.idx = ix; t.rdy = r; t.clr = c; t.rst = rs;
    t.ev = ev; t.eb = eb; t.em = em; t.ec = ec; t.erdy = erdy;
    return t;
  endfunction

  vec_t tbl[22];

  initial begin
    m_valid = '{0, 0}; m_bits = '{0, 0}; m_err = '{0, 0}; m_mask = '{0, 0};
    en = 0; idx = 0; rdy = 1; clr = 0; rst = 1;

    tbl[0]  = v(1'b0, 4'd0,  1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 0, 1'b1);
    tbl[1]  = v(1'b0, 4'd0,  1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 0, 1'b1);
    tbl[2]  = v(1'b1, 4'd0,  1'b1, 1'b0, 1'b0, 1'b1, 16'h0001, 16'h0001, 1, 1'b1);
    tbl[3]  = v(1'b1, 4'd1,  1'b1, 1'b0, 1'b0, 1'b1, 16'h0002, 16'h0003, 2, 1'b1);
    tbl[4]  = v(1'b1, 4'd2,  1'b1, 1'b0, 1'b0, 1'b1, 16'h0004, 16'h0007, 3, 1'b1);
    tbl[5]  = v(1'b1, 4'd15, 1'b1, 1'b0, 1'b0, 1'b1, 16'h8000, 16'h8007, 4, 1'b1);
    tbl[6]  = v(1'b0, 4'd0,  1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h8007, 4, 1'b1);
    tbl[7]  = v(1'b1, 4'd3,  1'b0, 1'b0, 1'b0, 1'b1, 16'h0008, 16'h800F, 5, 1'b0);
    tbl[8]  = v(1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 1'b1, 16'h0008, 16'h800F, 5, 1'b0);
    tbl[9]  = v(1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 1'b1, 16'h0008, 16'h800F, 5, 1'b0);
    tbl[10] = v(1'b1, 4'd5,  1'b0, 1'b0, 1'b0, 1'b1, 16'h0008, 16'h800F, 5, 1'b0);
    tbl[11] = v(1'b1, 4'd4,  1'b1, 1'b0, 1'b0, 1'b1, 16'h0010, 16'h801F, 6, 1'b1);
    tbl[12] = v(1'b0, 4'd0,  1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 0, 1'b1);
    tbl[13] = v(1'b1, 4'd4,  1'b1, 1'b0, 1'b0, 1'b1, 16'h0010, 16'h0010, 1, 1'b1);
    tbl[14] = v(1'b1, 4'd5,  1'b1, 1'b0, 1'b0, 1'b1, 16'h0020, 16'h0030, 2, 1'b1);
    tbl[15] = v(1'b1, 4'd6,  1'b1, 1'b0, 1'b0, 1'b1, 16'h0040, 16'h0070, 3, 1'b1);
    tbl[16] = v(1'b1, 4'd7,  1'b1, 1'b0, 1'b0, 1'b1, 16'h0080, 16'h00F0, 4, 1'b1);
    tbl[17] = v(1'b1, 4'd9,  1'b1, 1'b1, 1'b0, 1'b1, 16'h0200, 16'h0200, 1, 1'b1);
    tbl[18] = v(1'b1, 4'd9,  1'b1, 1'b0, 1'b0, 1'b1, 16'h0200, 16'h0200, 1, 1'b1);
    tbl[19] = v(1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 1'b1, 16'h0200, 16'h0200, 1, 1'b0);
    tbl[20] = v(1'b1, 4'd3,  1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 0, 1'b1);
    tbl[21] = v(1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 0, 1'b1);

    @(posedge clk); #1;
    for (int i = 0; i < 22; i++) begin
      cyc(tbl[i].en, tbl[i].idx, tbl[i].rdy, tbl[i].clr, tbl[i].rst);
      chk($sformatf("tbl%0d_valid", i), a_valid, tbl[i].ev);
      chk($sformatf("tbl%0d_mask", i),  a_mask,  tbl[i].em);
      chk($sformatf("tbl%0d_count", i), a_count, tbl[i].ec);
      chk($sformatf("tbl%0d_ready", i), a_ready, tbl[i].erdy);
      if (tbl[i].ev) chk($sformatf("tbl%0d_bits", i), a_bits, tbl[i].eb);
    end

    // Out-of-range on the 12-bit instance: zero bits, error flag, mask kept.
    cyc(1'b1, 4'd5, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 4'd13, 1'b1, 1'b0, 1'b0);
    chk("oor_valid", b_valid, 1'b1);
    chk("oor_bits",  b_bits,  12'h000);
    chk("oor_err",   b_err,   1'b1);
    chk("oor_mask",  b_mask,  12'h020);
    chk("oor_count", b_count, 4'd1);
    cyc(1'b1, 4'd11, 1'b1, 1'b0, 1'b0);
    chk("inr_err",   b_err,   1'b0);
    chk("inr_bits",  b_bits,  12'h800);

    for (int n = 0; n < 800; n++) begin
      logic e, r, c, rs;
      e  = ($urandom_range(0, 3) != 0);
      r  = ($urandom_range(0, 2) != 0);
      c  = ($urandom_range(0, 15) == 0);
      rs = ($urandom_range(0, 63) == 0);
      cyc(e, 4'($urandom_range(0, 15)), r, c, rs);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
